time_edit_engine: RTL and testbench

// Consumer side of the key-manager interface (editMode/disMode/editCur): holds the live time,

---
 rtl/time_edit_engine_pkg.sv | 97 +++++++++
 rtl/time_edit_engine_if.sv | 36 +++
 rtl/time_edit_engine_field_stepper.sv | 25 ++
 rtl/time_edit_engine.sv | 196 +++++++++++++++++++
 tb/tb_time_edit_engine.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/time_edit_engine_pkg.sv
// Shared types for the time/date/alarm edit engine.
// disMode codes, editable field ids, field ranges, days-in-month and cursor decode.
package clock_pkg;

    localparam logic [1:0] DM_TIME  = 2'd0;
    localparam logic [1:0] DM_DATE  = 2'd1;
    localparam logic [1:0] DM_ALARM = 2'd2;

    localparam logic [6:0] R_SEC  = 7'd60;
    localparam logic [6:0] R_HOUR = 7'd24;
    localparam logic [6:0] R_H12  = 7'd12;
    localparam logic [6:0] R_YEAR = 7'd100;

    typedef enum logic [3:0] {
        F_NONE,
        F_SEC,
        F_MIN,
        F_HOUR,
        F_HOUR12,
        F_DAY,
        F_MON,
        F_YEAR,
        F_AMIN,
        F_AHOUR,
        F_AEN
    } field_e;

    typedef struct packed {
        field_e     field;
        logic [6:0] step;
    } fstep_t;

    function automatic logic [4:0] dim(input logic [3:0] month,
                                       input logic [6:0] year);
        logic [4:0] d;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:    d = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default: d = 5'd31;
        endcase
        return d;
    endfunction

    // The pm toggle in the 12h layout is a +/-12 step on the 0..23 hour,
    // and the alarm enable toggle is a step of 1 on a range of 2.
    function automatic fstep_t cur2field(input logic [1:0] dm,
                                         input logic       sw,
                                         input logic [2:0] cur);
        fstep_t r;
        r.field = F_NONE;
        r.step  = cur[0] ? 7'd10 : 7'd1;
        case (dm)
            DM_DATE: begin
                case (cur)
                    3'd0, 3'd1: r.field = F_YEAR;
                    3'd2, 3'd3: r.field = F_MON;
                    3'd4, 3'd5: r.field = F_DAY;
                    default:    r.field = F_NONE;
                endcase
            end
            DM_ALARM: begin
                case (cur)
                    3'd0:       r.field = F_AEN;
                    3'd2, 3'd3: r.field = F_AMIN;
                    3'd4, 3'd5: r.field = F_AHOUR;
                    default:    r.field = F_NONE;
                endcase
            end
            default: begin
                if (!sw) begin
                    case (cur)
                        3'd0, 3'd1: r.field = F_SEC;
                        3'd2, 3'd3: r.field = F_MIN;
                        3'd4, 3'd5: r.field = F_HOUR;
                        default:    r.field = F_NONE;
                    endcase
                end else begin
                    case (cur)
                        3'd0: begin
                            r.field = F_HOUR;
                            r.step  = 7'd12;
                        end
                        3'd2, 3'd3: r.field = F_SEC;
                        3'd4, 3'd5: r.field = F_MIN;
                        3'd7: begin
                            r.field = F_HOUR12;
                            r.step  = 7'd1;
                        end
                        default: r.field = F_NONE;
                    endcase
                end
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/time_edit_engine_if.sv
// Key-manager / display bus of the time edit engine.
// master drives keys and ticks; slave (the engine) drives time, date, alarm and display.
interface time_edit_engine_if;
    logic       editMode;
    logic [1:0] disMode;
    logic [2:0] editCur;
    logic       SW;
    logic       incP;
    logic       decP;
    logic       tick1Hz;
    logic       blinkTick;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic [4:0] almHour;
    logic [5:0] almMin;
    logic       almEn;
    logic       pm;
    logic [7:0] blinkMask;
    logic       alarmHit;

    modport master (
        output editMode, disMode, editCur, SW, incP, decP, tick1Hz, blinkTick,
        input  hour, min, sec, day, month, year, almHour, almMin, almEn,
        input  pm, blinkMask, alarmHit
    );

    modport slave (
        input  editMode, disMode, editCur, SW, incP, decP, tick1Hz, blinkTick,
        output hour, min, sec, day, month, year, almHour, almMin, almEn,
        output pm, blinkMask, alarmHit
    );
endinterface

// File: rtl/time_edit_engine_field_stepper.sv
// Wrapping +/-step on a 0- or 1-based field of range 2..100.
// Ports: val_i/range_i/step_i/base1_i/inc_i in, val_o wrapped result out.
module field_stepper (
    input  logic [6:0] val_i,
    input  logic [6:0] range_i,
    input  logic [6:0] step_i,
    input  logic       base1_i,
    input  logic       inc_i,
    output logic [6:0] val_o
);
    logic [7:0] v0;
    logic [7:0] rng;
    logic [7:0] sum;
    logic [7:0] red;

    // step is always below range, so one conditional subtract wraps.
    always_comb begin
        v0    = {1'b0, val_i} - {7'd0, base1_i};
        rng   = {1'b0, range_i};
        sum   = inc_i ? (v0 + {1'b0, step_i})
                      : (v0 + rng - {1'b0, step_i});
        red   = (sum >= rng) ? (sum - rng) : sum;
        val_o = red[6:0] + {6'd0, base1_i};
    end
endmodule

// File: rtl/time_edit_engine.sv
// Live time/date/alarm registers with 1 Hz counting, cursor edits, blink and alarm pulse.
// Ports: Clk, Rst_n (sync, active-low), bus (slave modport of time_edit_engine_if).
module time_edit_engine
    import clock_pkg::*;
#(
    parameter logic [6:0] YEAR_RST   = 7'd0,
    parameter logic       ALM_RST_EN = 1'b0
) (
    input  logic                Clk,
    input  logic                Rst_n,
    time_edit_engine_if.slave   bus
);
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic [4:0] day_q, day_d;
    logic [3:0] mon_q, mon_d;
    logic [6:0] year_q, year_d;
    logic [4:0] ahour_q, ahour_d;
    logic [5:0] amin_q, amin_d;
    logic       aen_q, aen_d;
    logic       phase_q, phase_d;
    logic       hit_q, hit_d;

    logic [1:0] dm;
    fstep_t     cf;
    logic       edit_go;
    logic       tick_go;
    logic       pm;
    logic [4:0] h12;
    logic [4:0] dnew;
    logic [6:0] st_val, st_rng, st_out;
    logic       st_b1;

    assign dm      = (bus.disMode == 2'd3) ? DM_TIME : bus.disMode;
    assign cf      = cur2field(dm, bus.SW, bus.editCur);
    assign edit_go = bus.editMode & (bus.incP ^ bus.decP)
                   & (cf.field != F_NONE);
    assign tick_go = bus.tick1Hz & ~bus.editMode;
    assign pm      = (hour_q >= 5'd12);

    always_comb begin
        if (hour_q == 5'd0)       h12 = 5'd12;
        else if (hour_q > 5'd12)  h12 = hour_q - 5'd12;
        else                      h12 = hour_q;
    end

    always_comb begin
        st_val = 7'd0;
        st_rng = 7'd1;
        st_b1  = 1'b0;
        case (cf.field)
            F_SEC:    begin st_val = {1'b0, sec_q};   st_rng = R_SEC;  end
            F_MIN:    begin st_val = {1'b0, min_q};   st_rng = R_SEC;  end
            F_HOUR:   begin st_val = {2'b0, hour_q};  st_rng = R_HOUR; end
            F_HOUR12: begin
                st_val = {2'b0, h12};
                st_rng = R_H12;
                st_b1  = 1'b1;
            end
            F_DAY: begin
                st_val = {2'b0, day_q};
                st_rng = {2'b0, dim(mon_q, year_q)};
                st_b1  = 1'b1;
            end
            F_MON: begin
                st_val = {3'b0, mon_q};
                st_rng = 7'd12;
                st_b1  = 1'b1;
            end
            F_YEAR:   begin st_val = year_q;           st_rng = R_YEAR; end
            F_AMIN:   begin st_val = {1'b0, amin_q};   st_rng = R_SEC;  end
            F_AHOUR:  begin st_val = {2'b0, ahour_q};  st_rng = R_HOUR; end
            F_AEN:    begin st_val = {6'b0, aen_q};    st_rng = 7'd2;   end
            default:  ;
        endcase
    end

    field_stepper u_step (
        .val_i   (st_val),
        .range_i (st_rng),
        .step_i  (cf.step),
        .base1_i (st_b1),
        .inc_i   (bus.incP),
        .val_o   (st_out)
    );

    always_comb begin
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        day_d   = day_q;
        mon_d   = mon_q;
        year_d  = year_q;
        ahour_d = ahour_q;
        amin_d  = amin_q;
        aen_d   = aen_q;
        hit_d   = 1'b0;
        dnew    = 5'd31;
        phase_d = edit_go   ? 1'b1 :
                  bus.blinkTick ? ~phase_q : phase_q;

        if (edit_go) begin
            case (cf.field)
                F_SEC:    sec_d  = st_out[5:0];
                F_MIN:    min_d  = st_out[5:0];
                F_HOUR:   hour_d = st_out[4:0];
                // 12 maps back to 0 within the kept am/pm half.
                F_HOUR12: hour_d = ((st_out[4:0] == 5'd12) ? 5'd0 : st_out[4:0])
                                 + (pm ? 5'd12 : 5'd0);
                F_DAY:    day_d   = st_out[4:0];
                F_MON:    mon_d   = st_out[3:0];
                F_YEAR:   year_d  = st_out;
                F_AMIN:   amin_d  = st_out[5:0];
                F_AHOUR:  ahour_d = st_out[4:0];
                F_AEN:    aen_d   = st_out[0];
                default:  ;
            endcase
            dnew = dim(mon_d, year_d);
            if ((cf.field == F_MON || cf.field == F_YEAR) && day_q > dnew)
                day_d = dnew;
        end else if (tick_go) begin
            if (sec_q != 6'd59) begin
                sec_d = sec_q + 6'd1;
            end else begin
                sec_d = 6'd0;
                if (min_q != 6'd59) begin
                    min_d = min_q + 6'd1;
                end else begin
                    min_d = 6'd0;
                    if (hour_q != 5'd23) begin
                        hour_d = hour_q + 5'd1;
                    end else begin
                        hour_d = 5'd0;
                        if (day_q < dim(mon_q, year_q)) begin
                            day_d = day_q + 5'd1;
                        end else begin
                            day_d = 5'd1;
                            if (mon_q != 4'd12) begin
                                mon_d = mon_q + 4'd1;
                            end else begin
                                mon_d  = 4'd1;
                                year_d = (year_q == 7'd99) ? 7'd0
                                                           : year_q + 7'd1;
                            end
                        end
                    end
                end
            end
            hit_d = (sec_d == 6'd0) && (hour_d == ahour_q)
                  && (min_d == amin_q) && aen_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            hour_q  <= 5'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            day_q   <= 5'd1;
            mon_q   <= 4'd1;
            year_q  <= YEAR_RST;
            ahour_q <= 5'd0;
            amin_q  <= 6'd0;
            aen_q   <= ALM_RST_EN;
            phase_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            day_q   <= day_d;
            mon_q   <= mon_d;
            year_q  <= year_d;
            ahour_q <= ahour_d;
            amin_q  <= amin_d;
            aen_q   <= aen_d;
            phase_q <= phase_d;
            hit_q   <= hit_d;
        end
    end

    assign bus.hour      = hour_q;
    assign bus.min       = min_q;
    assign bus.sec       = sec_q;
    assign bus.day       = day_q;
    assign bus.month     = mon_q;
    assign bus.year      = year_q;
    assign bus.almHour   = ahour_q;
    assign bus.almMin    = amin_q;
    assign bus.almEn     = aen_q;
    assign bus.pm        = pm;
    assign bus.alarmHit  = hit_q;
    assign bus.blinkMask = (bus.editMode & phase_q) ? (8'd1 << bus.editCur)
                                                    : 8'd0;
endmodule

// File: tb/tb_time_edit_engine.sv
// Scoreboard bench for time_edit_engine: reference model on seconds-of-day plus date.
// Directed scenarios then randomized key/tick traffic; a monitor compares every cycle.
module tb_time_edit_engine;

    logic Clk;
    logic Rst_n;

    time_edit_engine_if bus ();

    time_edit_engine dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int hour, min, sec, day, month, year, ah, am, aen, pm, hit, mask;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int m_sod, m_day, m_mon, m_year, m_ah, m_am;
    bit m_aen, m_ph, m_hit;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, want, $time);
        end
    endtask

    function automatic int wrap(input int v, input int lo, input int n, input int dl);
        return ((v - lo + dl) % n + n) % n + lo;
    endfunction

    function automatic int mdays(input int mo, input int yr);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo == 2 && yr % 4 == 0) return 29;
        return t[mo-1];
    endfunction

    task automatic model(input bit rst, input bit em, input bit [1:0] dm,
                         input bit [2:0] cur, input bit sw, input bit inc,
                         input bit dec, input bit tk, input bit bt);
        int h, mi, s, dl, st, dme, h12;
        bit ap;
        if (!rst) begin
            m_sod = 0; m_day = 1; m_mon = 1; m_year = 0;
            m_ah = 0; m_am = 0; m_aen = 0; m_ph = 0; m_hit = 0;
            return;
        end
        h   = m_sod / 3600;
        mi  = (m_sod / 60) % 60;
        s   = m_sod % 60;
        ap  = 0;
        m_hit = 0;
        dl  = inc ? 1 : -1;
        st  = (cur % 2 == 1) ? 10 * dl : dl;
        dme = (dm == 3) ? 0 : int'(dm);
        if (em && (inc != dec)) begin
            ap = 1;
            if (dme == 0 && !sw) begin
                case (cur)
                    0, 1: s  = wrap(s, 0, 60, st);
                    2, 3: mi = wrap(mi, 0, 60, st);
                    4, 5: h  = wrap(h, 0, 24, st);
                    default: ap = 0;
                endcase
            end else if (dme == 0) begin
                case (cur)
                    0: h = (h + 12) % 24;
                    2, 3: s  = wrap(s, 0, 60, st);
                    4, 5: mi = wrap(mi, 0, 60, st);
                    7: begin
                        h12 = (h % 12 == 0) ? 12 : h % 12;
                        h12 = wrap(h12, 1, 12, dl);
                        h = (h12 % 12) + ((h >= 12) ? 12 : 0);
                    end
                    default: ap = 0;
                endcase
            end else if (dme == 1) begin
                case (cur)
                    0, 1: m_year = wrap(m_year, 0, 100, st);
                    2, 3: m_mon  = wrap(m_mon, 1, 12, st);
                    4, 5: m_day  = wrap(m_day, 1, mdays(m_mon, m_year), st);
                    default: ap = 0;
                endcase
                if (m_day > mdays(m_mon, m_year)) m_day = mdays(m_mon, m_year);
            end else begin
                case (cur)
                    0: m_aen = !m_aen;
                    2, 3: m_am = wrap(m_am, 0, 60, st);
                    4, 5: m_ah = wrap(m_ah, 0, 24, st);
                    default: ap = 0;
                endcase
            end
            m_sod = h * 3600 + mi * 60 + s;
        end else if (!em && tk) begin
            m_sod++;
            if (m_sod == 86400) begin
                m_sod = 0;
                m_day++;
                if (m_day > mdays(m_mon, m_year)) begin
                    m_day = 1;
                    m_mon++;
                    if (m_mon > 12) begin
                        m_mon = 1;
                        m_year = (m_year + 1) % 100;
                    end
                end
            end
            if (m_sod % 60 == 0 && m_sod / 3600 == m_ah
                && (m_sod / 60) % 60 == m_am && m_aen)
                m_hit = 1;
        end
        if (ap) m_ph = 1;
        else if (bt) m_ph = !m_ph;
    endtask

    task automatic cyc(input bit rst, input bit em, input bit [1:0] dm,
                       input bit [2:0] cur, input bit sw, input bit inc,
                       input bit dec, input bit tk, input bit bt);
        exp_t e;
        @(negedge Clk);
        Rst_n         = rst;
        bus.editMode  = em;
        bus.disMode   = dm;
        bus.editCur   = cur;
        bus.SW        = sw;
        bus.incP      = inc;
        bus.decP      = dec;
        bus.tick1Hz   = tk;
        bus.blinkTick = bt;
        model(rst, em, dm, cur, sw, inc, dec, tk, bt);
        e.hour  = m_sod / 3600;
        e.min   = (m_sod / 60) % 60;
        e.sec   = m_sod % 60;
        e.day   = m_day;
        e.month = m_mon;
        e.year  = m_year;
        e.ah    = m_ah;
        e.am    = m_am;
        e.aen   = int'(m_aen);
        e.pm    = (e.hour >= 12) ? 1 : 0;
        e.hit   = int'(m_hit);
        e.mask  = (em && m_ph) ? (1 << cur) : 0;
        exp_q.push_back(e);
    endtask

    task automatic ed(input bit [1:0] dm, input bit [2:0] cur, input bit sw,
                      input bit inc);
        cyc(1, 1, dm, cur, sw, inc, !inc, 0, 0);
    endtask

    task automatic tick();
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic settle();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_time(input int h, input int mi, input int s);
        int n = 0;
        while (m_sod / 3600 != h && n < 300) begin ed(0, 4, 0, 1); n++; end
        while ((m_sod / 60) % 60 != mi && n < 300) begin ed(0, 2, 0, 1); n++; end
        while (m_sod % 60 != s && n < 300) begin ed(0, 0, 0, 1); n++; end
    endtask

    task automatic set_date(input int d, input int mo, input int y);
        int n = 0;
        while (m_year != y && n < 300) begin ed(1, 0, 0, 1); n++; end
        while (m_mon != mo && n < 300) begin ed(1, 2, 0, 1); n++; end
        while (m_day != d && n < 300) begin ed(1, 4, 0, 1); n++; end
    endtask

    task automatic set_alm(input int h, input int mi, input bit en);
        int n = 0;
        while (m_ah != h && n < 300) begin ed(2, 4, 0, 1); n++; end
        while (m_am != mi && n < 300) begin ed(2, 2, 0, 1); n++; end
        if (m_aen != en) ed(2, 0, 0, 1);
    endtask

    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_hour",  int'(bus.hour),      e.hour);
            chk("sb_min",   int'(bus.min),       e.min);
            chk("sb_sec",   int'(bus.sec),       e.sec);
            chk("sb_day",   int'(bus.day),       e.day);
            chk("sb_month", int'(bus.month),     e.month);
            chk("sb_year",  int'(bus.year),      e.year);
            chk("sb_ahour", int'(bus.almHour),   e.ah);
            chk("sb_amin",  int'(bus.almMin),    e.am);
            chk("sb_aen",   int'(bus.almEn),     e.aen);
            chk("sb_pm",    int'(bus.pm),        e.pm);
            chk("sb_hit",   int'(bus.alarmHit),  e.hit);
            chk("sb_mask",  int'(bus.blinkMask), e.mask);
        end
    end

    initial begin
        Rst_n = 1'b0;
        bus.editMode = 0; bus.disMode = 0; bus.editCur = 0; bus.SW = 0;
        bus.incP = 0; bus.decP = 0; bus.tick1Hz = 0; bus.blinkTick = 0;

        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 1, 0, 1, 0);
        settle();
        chk("rst_hour", int'(bus.hour), 0);
        chk("rst_sec", int'(bus.sec), 0);
        chk("rst_day", int'(bus.day), 1);
        chk("rst_month", int'(bus.month), 1);
        chk("rst_year", int'(bus.year), 0);
        chk("rst_aen", int'(bus.almEn), 0);

        repeat (3599) tick();
        settle();
        chk("t3599_hour", int'(bus.hour), 0);
        chk("t3599_min", int'(bus.min), 59);
        chk("t3599_sec", int'(bus.sec), 59);
        tick();
        settle();
        chk("t3600_hour", int'(bus.hour), 1);
        chk("t3600_min", int'(bus.min), 0);
        chk("t3600_sec", int'(bus.sec), 0);
        chk("t3600_day", int'(bus.day), 1);

        set_date(28, 2, 23);
        set_time(23, 59, 59);
        tick();
        settle();
        chk("roll_hour", int'(bus.hour), 0);
        chk("roll_sec", int'(bus.sec), 0);
        chk("roll_day", int'(bus.day), 1);
        chk("roll_month", int'(bus.month), 3);
        chk("roll_year", int'(bus.year), 23);

        set_date(28, 2, 24);
        set_time(23, 59, 59);
        tick();
        settle();
        chk("leap_day", int'(bus.day), 29);
        chk("leap_month", int'(bus.month), 2);

        set_time(0, 55, 0);
        ed(0, 3, 0, 1);
        settle();
        chk("min10_inc", int'(bus.min), 5);
        set_time(0, 0, 0);
        ed(0, 2, 0, 0);
        settle();
        chk("min_dec", int'(bus.min), 59);

        set_time(13, 0, 0);
        ed(0, 0, 1, 1);
        settle();
        chk("pmtog_hour", int'(bus.hour), 1);
        chk("pmtog_pm", int'(bus.pm), 0);
        set_time(0, 0, 0);
        ed(0, 7, 1, 1);
        settle();
        chk("h12_hour", int'(bus.hour), 1);
        chk("h12_pm", int'(bus.pm), 0);

        set_date(31, 1, 23);
        ed(1, 2, 0, 1);
        settle();
        chk("clamp_month", int'(bus.month), 2);
        chk("clamp_day", int'(bus.day), 28);
        cyc(1, 1, 1, 2, 0, 1, 1, 0, 0);
        settle();
        chk("both_month", int'(bus.month), 2);
        chk("both_day", int'(bus.day), 28);

        set_alm(7, 30, 1);
        set_time(7, 29, 59);
        tick();
        settle();
        chk("alm_hit", int'(bus.alarmHit), 1);
        chk("alm_min", int'(bus.min), 30);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("alm_pulse", int'(bus.alarmHit), 0);
        set_time(7, 29, 59);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 0);
        settle();
        chk("edit_nohit", int'(bus.alarmHit), 0);
        chk("edit_frozen", int'(bus.sec), 59);
        ed(0, 3, 0, 1);
        cyc(1, 1, 0, 3, 0, 0, 0, 0, 0);
        settle();
        chk("blink_on", int'(bus.blinkMask), 8);
        cyc(1, 0, 0, 3, 0, 0, 0, 0, 0);
        settle();
        chk("blink_off", int'(bus.blinkMask), 0);

        for (int i = 0; i < 1500; i++) begin
            bit em, sw, inc, dec, tk, bt, rst;
            int pk;
            rst = ($urandom_range(0, 299) != 0);
            em  = ($urandom_range(0, 9) < 5);
            sw  = $urandom_range(0, 1);
            pk  = $urandom_range(0, 6);
            inc = (pk == 1 || pk == 2 || pk == 5);
            dec = (pk == 3 || pk == 4 || pk == 5);
            tk  = ($urandom_range(0, 2) == 0);
            bt  = ($urandom_range(0, 3) == 0);
            cyc(rst, em, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                sw, inc, dec, tk, bt);
        end

        repeat (3) @(posedge Clk);
        #2;
        chk("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
